eeprom_arbiter: RTL and testbench
=================================

EEPROM_ARBITER -- requirements
Module: eeprom_arbiter

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous, active-high reset, rst; all other ports are synchronous to clk.
REQ-002 Parameter TIMEOUT, default 16'd50000: cycles allowed from engine issue to eng_done before the transaction is aborted.
REQ-003 Ports (name  direction  width  meaning):
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req0 / req1  in  1  requester N wants one byte transaction; held until gntN
- we0 / we1  in  1  1 = byte write, 0 = byte read
- addr0 / addr1  in  8  EEPROM byte address (0x00-0xFF)
- wdata0 / wdata1  in  8  write byte
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted, inputs latched
- done0 / done1  out  1  one-cycle pulse: transaction finished
- rdata0 / rdata1  out  8  read byte, valid while doneN=1
- err0 / err1  out  1  valid while doneN=1: NACK or timeout
- eng_req  out  1  transaction request to the I2C byte engine
- eng_we  out  1  latched write enable
- eng_addr  out  8  latched address
- eng_wdata  out  8  latched write byte
- eng_busy  in  1  engine has accepted and is running
- eng_done  in  1  one-cycle completion pulse from engine
- eng_rdata  in  8  read byte, valid with eng_done
- eng_nack  in  1  device NACKed, valid with eng_done

Function
REQ-004 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; only one transaction is outstanding at any time.
REQ-005 IDLE: if req0|req1 is sampled at edge N, at edge N the FSM SHALL latch the winner's we/addr/wdata, record the winner, and move to ISSUE; gnt(winner) is high for exactly the cycle following edge N.
REQ-006 A request still high in IDLE after its grant SHALL be treated as a new request.
REQ-007 ISSUE: eng_req SHALL be 1, with eng_we/eng_addr/eng_wdata stable, until eng_busy=1 is sampled, then go to WAIT with eng_req=0 from that edge.
REQ-008 WAIT: on eng_done=1 the FSM SHALL capture eng_rdata into rdata(winner), set err(winner)=eng_nack, and go to RESP.
REQ-009 A 16-bit timeout counter SHALL clear on entry to ISSUE and increment each cycle in ISSUE and WAIT; on reaching TIMEOUT it SHALL force RESP with err=1 and rdata=8'h00, and eng_req=0.
REQ-010 If eng_done and timeout coincide, eng_done SHALL win (err=eng_nack).
REQ-011 RESP: done(winner) SHALL be 1 for exactly one cycle, then the FSM returns to IDLE; the non-winner's done/err stay 0.
REQ-012 Grant-to-done latency SHALL be at least 3 cycles (ISSUE, WAIT, RESP each at least one cycle).
REQ-013 rdataN SHALL hold its last captured value between transactions; eng_done outside WAIT SHALL be ignored.

Reset
REQ-014 On rst the block SHALL enter IDLE; all gnt/done/err/eng_req outputs SHALL be 0; rdata0/1, eng_addr, eng_wdata SHALL be 8'h00; eng_we SHALL be 0; the timeout counter SHALL be 0; the round-robin pointer SHALL be set so that port 0 wins next.
REQ-015 Reset mid-transaction SHALL abort it silently: no done pulse is issued for the aborted transaction.

Configuration
REQ-016 With ARB_ROUND_ROBIN_EN defined, on simultaneous req0 and req1 the port not granted last SHALL win; the pointer updates on every grant.
REQ-017 Without ARB_ROUND_ROBIN_EN, port 0 SHALL always win simultaneous requests (fixed priority); no pointer register is built.

Verification
REQ-018 Reset, then req0 read addr 0x3C; engine sets eng_busy after 2 cycles and eng_done with rdata 0xA5, nack=0 -> gnt0 pulse, eng_addr=0x3C, done0 pulse with rdata0=0xA5, err0=0.
REQ-019 req1 write addr 0x10, data 0x5A, engine returns eng_nack=1 -> done1 with err1=1; eng_we=1 and eng_wdata=0x5A throughout ISSUE.
REQ-020 req0 and req1 both held for 4 transactions, round-robin on -> grant order 0,1,0,1; round-robin off -> port 0 wins the first three grants and port 1 is granted only after req0 drops.
REQ-021 TIMEOUT=16'd20 with the engine never asserting eng_done -> done pulse exactly 20 cycles after ISSUE entry, err=1, rdata=0x00.
REQ-022 rst asserted for 1 cycle while in WAIT, then eng_done pulsed -> no done pulse, FSM in IDLE, all outputs at reset values.

Source files
------------

// File: rtl/eeprom_arbiter.sv
// eeprom_arbiter: two-port arbiter in front of a single I2C EEPROM byte engine.
// Grants one byte read/write at a time, issues it to the engine, and returns
// the result (or a timeout abort) to the winning requester.
//
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin arbitration on
// simultaneous requests; otherwise port 0 has fixed priority.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   reqN/weN/addrN/wdataN  requester N byte transaction (held until gntN)
//   gntN                   one-cycle pulse: request accepted, inputs latched
//   doneN/rdataN/errN      one-cycle completion pulse, read byte, NACK/timeout
//   eng_req/we/addr/wdata  request and latched fields to the byte engine
//   eng_busy/done          engine accepted / one-cycle completion pulse
//   eng_rdata/eng_nack     engine read byte and NACK flag, valid with eng_done
module eeprom_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [7:0] addr0,
    input  logic [7:0] addr1,
    input  logic [7:0] wdata0,
    input  logic [7:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] rdata0,
    output logic [7:0] rdata1,
    output logic       err0,
    output logic       err1,
    output logic       eng_req,
    output logic       eng_we,
    output logic [7:0] eng_addr,
    output logic [7:0] eng_wdata,
    input  logic       eng_busy,
    input  logic       eng_done,
    input  logic [7:0] eng_rdata,
    input  logic       eng_nack
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t      r_state;
    logic        r_win;
    logic [15:0] r_cnt;
    logic        r_gnt0;
    logic        r_gnt1;
    logic        r_done0;
    logic        r_done1;
    logic        r_err0;
    logic        r_err1;
    logic [7:0]  r_rdata0;
    logic [7:0]  r_rdata1;
    logic        r_eng_req;
    logic        r_eng_we;
    logic [7:0]  r_eng_addr;
    logic [7:0]  r_eng_wdata;

    logic        w_pick;
    logic [15:0] w_cnt_inc;
    logic        w_timeout;

`ifdef ARB_ROUND_ROBIN_EN
    // Port granted most recently; the other port wins a tie.
    logic r_last;

    always_comb begin
        w_pick = (req0 & req1) ? ~r_last : req1;
    end
`else
    always_comb begin
        w_pick = ~req0;
    end
`endif

    // Counter reads k-1 during the k-th cycle after ISSUE entry, so the
    // abort edge is the one at which the count would reach TIMEOUT.
    assign w_cnt_inc = r_cnt + 16'd1;
    assign w_timeout = (w_cnt_inc == TIMEOUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_win       <= 1'b0;
            r_cnt       <= 16'd0;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_err0      <= 1'b0;
            r_err1      <= 1'b0;
            r_rdata0    <= 8'h00;
            r_rdata1    <= 8'h00;
            r_eng_req   <= 1'b0;
            r_eng_we    <= 1'b0;
            r_eng_addr  <= 8'h00;
            r_eng_wdata <= 8'h00;
`ifdef ARB_ROUND_ROBIN_EN
            r_last      <= 1'b1;
`endif
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (req0 | req1) begin
                        r_win       <= w_pick;
                        r_gnt0      <= ~w_pick;
                        r_gnt1      <= w_pick;
                        r_eng_we    <= w_pick ? we1 : we0;
                        r_eng_addr  <= w_pick ? addr1 : addr0;
                        r_eng_wdata <= w_pick ? wdata1 : wdata0;
                        r_eng_req   <= 1'b1;
                        r_cnt       <= 16'd0;
                        r_state     <= ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last      <= w_pick;
`endif
                    end
                end
                ISSUE: begin
                    r_cnt <= w_cnt_inc;
                    if (w_timeout) begin
                        r_eng_req <= 1'b0;
                        r_done0   <= ~r_win;
                        r_done1   <= r_win;
                        r_err0    <= ~r_win;
                        r_err1    <= r_win;
                        if (r_win) r_rdata1 <= 8'h00;
                        else       r_rdata0 <= 8'h00;
                        r_state   <= RESP;
                    end else if (eng_busy) begin
                        r_eng_req <= 1'b0;
                        r_state   <= WAIT;
                    end
                end
                WAIT: begin
                    r_cnt <= w_cnt_inc;
                    // A completion on the timeout edge still counts.
                    if (eng_done) begin
                        r_done0 <= ~r_win;
                        r_done1 <= r_win;
                        r_err0  <= ~r_win & eng_nack;
                        r_err1  <= r_win & eng_nack;
                        if (r_win) r_rdata1 <= eng_rdata;
                        else       r_rdata0 <= eng_rdata;
                        r_state <= RESP;
                    end else if (w_timeout) begin
                        r_done0 <= ~r_win;
                        r_done1 <= r_win;
                        r_err0  <= ~r_win;
                        r_err1  <= r_win;
                        if (r_win) r_rdata1 <= 8'h00;
                        else       r_rdata0 <= 8'h00;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign err0      = r_err0;
    assign err1      = r_err1;
    assign rdata0    = r_rdata0;
    assign rdata1    = r_rdata1;
    assign eng_req   = r_eng_req;
    assign eng_we    = r_eng_we;
    assign eng_addr  = r_eng_addr;
    assign eng_wdata = r_eng_wdata;

endmodule

// File: tb/tb_eeprom_arbiter.sv
// tb_eeprom_arbiter: directed bench for eeprom_arbiter with TIMEOUT=20.
// Drives a hand-scripted engine and checks each step against fixed values.
module tb_eeprom_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic       we0 = 1'b0;
    logic       we1 = 1'b0;
    logic [7:0] addr0 = 8'h00;
    logic [7:0] addr1 = 8'h00;
    logic [7:0] wdata0 = 8'h00;
    logic [7:0] wdata1 = 8'h00;
    logic       gnt0;
    logic       gnt1;
    logic       done0;
    logic       done1;
    logic [7:0] rdata0;
    logic [7:0] rdata1;
    logic       err0;
    logic       err1;
    logic       eng_req;
    logic       eng_we;
    logic [7:0] eng_addr;
    logic [7:0] eng_wdata;
    logic       eng_busy = 1'b0;
    logic       eng_done = 1'b0;
    logic [7:0] eng_rdata = 8'h00;
    logic       eng_nack = 1'b0;

    int n_checks = 0;
    int n_err = 0;

    eeprom_arbiter #(.TIMEOUT(16'd20)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1),
        .rdata0(rdata0), .rdata1(rdata1),
        .err0(err0), .err1(err1),
        .eng_req(eng_req), .eng_we(eng_we),
        .eng_addr(eng_addr), .eng_wdata(eng_wdata),
        .eng_busy(eng_busy), .eng_done(eng_done),
        .eng_rdata(eng_rdata), .eng_nack(eng_nack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int order [4];
    int g;
    int early;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        order = '{0, 1, 0, 1};
`else
        order = '{0, 0, 0, 1};
`endif
        // Reset values
        tick();
        tick();
        chk("rst_gnt", {gnt1, gnt0}, 16'd0);
        chk("rst_done", {done1, done0}, 16'd0);
        chk("rst_err", {err1, err0}, 16'd0);
        chk("rst_rdata", {rdata1, rdata0}, 16'h0000);
        chk("rst_eng", {eng_req, eng_we}, 16'd0);
        chk("rst_eng_aw", {eng_addr, eng_wdata}, 16'h0000);
        rst = 1'b0;
        tick();

        // Port 0 read of 0x3C, data 0xA5
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h3C;
        tick();
        chk("t1_gnt0", gnt0, 1);
        chk("t1_gnt1", gnt1, 0);
        chk("t1_eng_req", eng_req, 1);
        chk("t1_eng_addr", eng_addr, 16'h3C);
        chk("t1_eng_we", eng_we, 0);
        req0 = 1'b0;
        tick();
        chk("t1_gnt0_pulse", gnt0, 0);
        chk("t1_eng_req_hold", eng_req, 1);
        eng_busy = 1'b1;
        tick();
        chk("t1_eng_req_drop", eng_req, 0);
        chk("t1_no_done", done0, 0);
        eng_busy = 1'b0;
        eng_done = 1'b1; eng_rdata = 8'hA5; eng_nack = 1'b0;
        tick();
        eng_done = 1'b0;
        chk("t1_done0", done0, 1);
        chk("t1_done1", done1, 0);
        chk("t1_rdata0", rdata0, 16'hA5);
        chk("t1_err0", err0, 0);
        tick();
        chk("t1_done0_pulse", done0, 0);
        chk("t1_rdata0_hold", rdata0, 16'hA5);

        // Port 1 write 0x5A to 0x10, NACK
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'h10; wdata1 = 8'h5A;
        tick();
        chk("t2_gnt1", gnt1, 1);
        chk("t2_gnt0", gnt0, 0);
        chk("t2_eng_we", eng_we, 1);
        chk("t2_eng_wdata", eng_wdata, 16'h5A);
        chk("t2_eng_addr", eng_addr, 16'h10);
        req1 = 1'b0;
        tick();
        chk("t2_issue_we", {eng_req, eng_we}, 16'd3);
        chk("t2_issue_wdata", eng_wdata, 16'h5A);
        eng_busy = 1'b1;
        tick();
        eng_busy = 1'b0;
        eng_done = 1'b1; eng_rdata = 8'h33; eng_nack = 1'b1;
        tick();
        eng_done = 1'b0; eng_nack = 1'b0;
        chk("t2_done1", done1, 1);
        chk("t2_err1", err1, 1);
        chk("t2_done0_err0", {done0, err0}, 16'd0);
        chk("t2_rdata1", rdata1, 16'h33);
        chk("t2_rdata0_hold", rdata0, 16'hA5);
        tick();
        chk("t2_idle", {done1, err1}, 16'd0);

        // Stray eng_done in IDLE is ignored
        eng_done = 1'b1; eng_rdata = 8'h77;
        tick();
        eng_done = 1'b0;
        tick();
        chk("stray_done", {done1, done0}, 16'd0);
        chk("stray_rdata", {rdata1, rdata0}, 16'h33A5);

        // Both requesters held for four transactions
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h20; addr1 = 8'h21;
        for (int t = 0; t < 4; t++) begin
            tick();
            g = order[t];
            chk("arb_gnt0", gnt0, (g == 0) ? 16'd1 : 16'd0);
            chk("arb_gnt1", gnt1, (g == 1) ? 16'd1 : 16'd0);
`ifndef ARB_ROUND_ROBIN_EN
            if (t == 2) req0 = 1'b0;
`endif
            if (t == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            eng_busy = 1'b1;
            tick();
            eng_busy = 1'b0;
            eng_done = 1'b1; eng_rdata = 8'hC0 + 8'(t);
            tick();
            eng_done = 1'b0;
            chk("arb_done0", done0, (g == 0) ? 16'd1 : 16'd0);
            chk("arb_done1", done1, (g == 1) ? 16'd1 : 16'd0);
            tick();
        end
        chk("arb_rdata", {rdata1, rdata0}, 16'hC3C2);

        // Timeout: engine goes busy but never completes
        req0 = 1'b1; addr0 = 8'h55;
        tick();
        chk("to_gnt0", gnt0, 1);
        req0 = 1'b0;
        eng_busy = 1'b1;
        early = 0;
        tick();
        eng_busy = 1'b0;
        if (done0) early++;
        for (int k = 2; k < 20; k++) begin
            tick();
            if (done0) early++;
        end
        chk("to_early_done", 16'(early), 16'd0);
        tick();
        chk("to_done0", done0, 1);
        chk("to_err0", err0, 1);
        chk("to_rdata0", rdata0, 16'h00);
        chk("to_eng_req", eng_req, 0);
        chk("to_done1", done1, 0);
        tick();
        chk("to_pulse", {done0, err0}, 16'd0);

        // eng_done on the timeout edge wins
        req0 = 1'b1; addr0 = 8'h56;
        tick();
        chk("co_gnt0", gnt0, 1);
        req0 = 1'b0;
        eng_busy = 1'b1;
        tick();
        eng_busy = 1'b0;
        for (int k = 2; k < 20; k++) tick();
        chk("co_no_done", done0, 0);
        eng_done = 1'b1; eng_nack = 1'b0; eng_rdata = 8'h99;
        tick();
        eng_done = 1'b0;
        chk("co_done0", done0, 1);
        chk("co_err0", err0, 0);
        chk("co_rdata0", rdata0, 16'h99);
        tick();

        // Reset while in WAIT aborts silently
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h77;
        tick();
        chk("rw_gnt1", gnt1, 1);
        req1 = 1'b0;
        eng_busy = 1'b1;
        tick();
        eng_busy = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        eng_done = 1'b1; eng_rdata = 8'hEE;
        tick();
        eng_done = 1'b0;
        chk("rw_done", {done1, done0}, 16'd0);
        chk("rw_err", {err1, err0}, 16'd0);
        chk("rw_gnt", {gnt1, gnt0}, 16'd0);
        chk("rw_rdata", {rdata1, rdata0}, 16'h0000);
        chk("rw_eng", {eng_req, eng_we}, 16'd0);
        chk("rw_eng_aw", {eng_addr, eng_wdata}, 16'h0000);
        tick();
        chk("rw_no_late_done", {done1, done0}, 16'd0);
        req0 = 1'b1; req1 = 1'b1;
        tick();
        chk("rw_idle_gnt0", gnt0, 1);
        chk("rw_idle_gnt1", gnt1, 0);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
